register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_mp_pkg.sv | 13 +
 rtl/register_file_mp_scoreboard.sv | 52 +++++
 rtl/register_file_mp.sv | 128 ++++++++++++
 tb/tb_register_file_mp.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package register_file_mp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NRD    = 2;

    // Address width for a given register count; a one-entry file still gets one bit.
    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Busy-bit scoreboard: one pending-writer flag per register.
// An issue sets a flag and a write clears it; when both hit the same
// register in one cycle, the issue wins so the flag stays set.
module rf_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = addrWidth(DEF_DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              issueEn_i,
    input  logic [ADDR_W-1:0] issueAddr_i,
    input  logic              wrEn0_i,
    input  logic [ADDR_W-1:0] wrAddr0_i,
    input  logic              wrEn1_i,
    input  logic [ADDR_W-1:0] wrAddr1_i,
    output logic [DEPTH-1:0]  busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy state: clear on write, then set on issue so the issue takes priority.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if ((wrEn0_i && wrAddr0_i == ADDR_W'(i)) || (wrEn1_i && wrAddr1_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (issueEn_i && issueAddr_i == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Busy array register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports (port 1 wins on collision),
// NRD registered read ports, and a busy scoreboard for pending writers.
// Define REGISTER_FILE_MP_BYPASS_EN to forward same-edge write data and
// busy clearing to the read ports.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NRD      = DEF_NRD,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = addrWidth(DEPTH)
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [ADDR_W-1:0]     W_Addr0,
    input  logic [DATA_W-1:0]     W_Data0,
    input  logic                  Write_Reg0,
    input  logic [ADDR_W-1:0]     W_Addr1,
    input  logic [DATA_W-1:0]     W_Data1,
    input  logic                  Write_Reg1,
    input  logic [NRD*ADDR_W-1:0] R_Addr,
    input  logic [NRD-1:0]        R_En,
    output logic [NRD*DATA_W-1:0] R_Data,
    output logic [NRD-1:0]        R_Valid,
    output logic [NRD-1:0]        R_Busy,
    input  logic                  Issue_En,
    input  logic [ADDR_W-1:0]     Issue_Addr
);

    logic [DATA_W-1:0]     regFile_q [DEPTH];
    logic [NRD*DATA_W-1:0] rData_q, rData_d;
    logic [NRD-1:0]        rValid_q, rValid_d;
    logic [NRD-1:0]        rBusy_q, rBusy_d;
    logic [DEPTH-1:0]      busy;
    logic                  wrOk0, wrOk1, issueOk;
    logic [ADDR_W-1:0]     rdAddr;

    // Writes and issues aimed at a hardwired zero register are dropped here.
    always_comb begin
        wrOk0   = Write_Reg0 && !(ZERO_REG != 0 && W_Addr0 == '0);
        wrOk1   = Write_Reg1 && !(ZERO_REG != 0 && W_Addr1 == '0);
        issueOk = Issue_En   && !(ZERO_REG != 0 && Issue_Addr == '0);
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) uScoreboard (
        .clk_i       (clk),
        .reset_i     (Reset),
        .issueEn_i   (issueOk),
        .issueAddr_i (Issue_Addr),
        .wrEn0_i     (wrOk0),
        .wrAddr0_i   (W_Addr0),
        .wrEn1_i     (wrOk1),
        .wrAddr1_i   (W_Addr1),
        .busy_o      (busy)
    );

    // Storage update; port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile_q[i] <= '0;
            end
        end else begin
            if (wrOk0) begin
                regFile_q[W_Addr0] <= W_Data0;
            end
            if (wrOk1) begin
                regFile_q[W_Addr1] <= W_Data1;
            end
        end
    end

    // Per-port read data, valid and busy; idle ports hold their last data and busy.
    always_comb begin
        rData_d  = rData_q;
        rValid_d = '0;
        rBusy_d  = rBusy_q;
        rdAddr   = '0;
        for (int k = 0; k < NRD; k++) begin
            rdAddr = R_Addr[k*ADDR_W +: ADDR_W];
            if (R_En[k]) begin
                rValid_d[k] = 1'b1;
`ifdef REGISTER_FILE_MP_BYPASS_EN
                if (wrOk1 && W_Addr1 == rdAddr) begin
                    rData_d[k*DATA_W +: DATA_W] = W_Data1;
                    rBusy_d[k] = issueOk && Issue_Addr == rdAddr;
                end else if (wrOk0 && W_Addr0 == rdAddr) begin
                    rData_d[k*DATA_W +: DATA_W] = W_Data0;
                    rBusy_d[k] = issueOk && Issue_Addr == rdAddr;
                end else begin
                    rData_d[k*DATA_W +: DATA_W] = regFile_q[rdAddr];
                    rBusy_d[k] = busy[rdAddr];
                end
`else
                rData_d[k*DATA_W +: DATA_W] = regFile_q[rdAddr];
                rBusy_d[k] = busy[rdAddr];
`endif
                if (ZERO_REG != 0 && rdAddr == '0) begin
                    rData_d[k*DATA_W +: DATA_W] = '0;
                    rBusy_d[k] = 1'b0;
                end
            end
        end
    end

    // Read output registers; reset drops any read requested in the same cycle.
    always_ff @(posedge clk) begin
        if (Reset) begin
            rData_q  <= '0;
            rValid_q <= '0;
            rBusy_q  <= '0;
        end else begin
            rData_q  <= rData_d;
            rValid_q <= rValid_d;
            rBusy_q  <= rBusy_d;
        end
    end

    assign R_Data  = rData_q;
    assign R_Valid = rValid_q;
    assign R_Busy  = rBusy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed testbench for register_file_mp with default parameters
// (32 x 32-bit, two read ports, register 0 hardwired to zero).
module tb_register_file_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;

    logic                  clk = 1'b0;
    logic                  Reset;
    logic [ADDR_W-1:0]     W_Addr0, W_Addr1, Issue_Addr;
    logic [DATA_W-1:0]     W_Data0, W_Data1;
    logic                  Write_Reg0, Write_Reg1, Issue_En;
    logic [NRD*ADDR_W-1:0] R_Addr;
    logic [NRD-1:0]        R_En;
    logic [NRD*DATA_W-1:0] R_Data;
    logic [NRD-1:0]        R_Valid;
    logic [NRD-1:0]        R_Busy;

    int checks = 0;
    int errors = 0;

    register_file_mp dut (
        .clk        (clk),
        .Reset      (Reset),
        .W_Addr0    (W_Addr0),
        .W_Data0    (W_Data0),
        .Write_Reg0 (Write_Reg0),
        .W_Addr1    (W_Addr1),
        .W_Data1    (W_Data1),
        .Write_Reg1 (Write_Reg1),
        .R_Addr     (R_Addr),
        .R_En       (R_En),
        .R_Data     (R_Data),
        .R_Valid    (R_Valid),
        .R_Busy     (R_Busy),
        .Issue_En   (Issue_En),
        .Issue_Addr (Issue_Addr)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Return every input to idle.
    task automatic applyStimulus();
        Reset      = 1'b0;
        W_Addr0    = '0;
        W_Data0    = '0;
        Write_Reg0 = 1'b0;
        W_Addr1    = '0;
        W_Data1    = '0;
        Write_Reg1 = 1'b0;
        R_Addr     = '0;
        R_En       = '0;
        Issue_En   = 1'b0;
        Issue_Addr = '0;
    endtask

    // Advance one rising edge and settle one unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] port(input int k);
        return R_Data[k*DATA_W +: DATA_W];
    endfunction

    initial begin
        applyStimulus();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        checkOutput("reset_valid", 32'(R_Valid), 32'd0);
        checkOutput("reset_data", R_Data[31:0] | R_Data[63:32], 32'd0);
        checkOutput("reset_busy", 32'(R_Busy), 32'd0);

        // Basic write then read with one-cycle latency.
        W_Addr0 = 5'd5; W_Data0 = 32'hDEADBEEF; Write_Reg0 = 1'b1;
        tick();
        applyStimulus();
        R_Addr = {5'd0, 5'd5}; R_En = 2'b01;
        tick();
        applyStimulus();
        checkOutput("rd5_data", port(0), 32'hDEADBEEF);
        checkOutput("rd5_valid", 32'(R_Valid), 32'd1);
        tick();
        checkOutput("idle_valid", 32'(R_Valid), 32'd0);
        checkOutput("idle_hold", port(0), 32'hDEADBEEF);

        // Same-address collision: port 1 data wins; both ports read it.
        W_Addr0 = 5'd7; W_Data0 = 32'h1111; Write_Reg0 = 1'b1;
        W_Addr1 = 5'd7; W_Data1 = 32'h2222; Write_Reg1 = 1'b1;
        tick();
        applyStimulus();
        R_Addr = {5'd7, 5'd7}; R_En = 2'b11;
        tick();
        applyStimulus();
        checkOutput("col_p0", port(0), 32'h2222);
        checkOutput("col_p1", port(1), 32'h2222);
        checkOutput("col_valid", 32'(R_Valid), 32'd3);

        // Independent ports on different addresses.
        R_Addr = {5'd5, 5'd7}; R_En = 2'b11;
        tick();
        applyStimulus();
        checkOutput("ind_p0", port(0), 32'h2222);
        checkOutput("ind_p1", port(1), 32'hDEADBEEF);

        // Register 0 ignores writes and issues.
        W_Addr0 = 5'd0; W_Data0 = 32'hFFFFFFFF; Write_Reg0 = 1'b1;
        W_Addr1 = 5'd0; W_Data1 = 32'hFFFFFFFF; Write_Reg1 = 1'b1;
        Issue_En = 1'b1; Issue_Addr = 5'd0;
        tick();
        applyStimulus();
        R_Addr = {5'd0, 5'd0}; R_En = 2'b11;
        tick();
        applyStimulus();
        checkOutput("zero_data", port(0), 32'd0);
        checkOutput("zero_busy", 32'(R_Busy), 32'd0);

        // Scoreboard: issue sets, write clears, issue+write stays set.
        Issue_En = 1'b1; Issue_Addr = 5'd3;
        tick();
        applyStimulus();
        R_Addr = {5'd0, 5'd3}; R_En = 2'b01;
        tick();
        applyStimulus();
        checkOutput("sb_set_busy", 32'(R_Busy[0]), 32'd1);
        W_Addr1 = 5'd3; W_Data1 = 32'h55; Write_Reg1 = 1'b1;
        tick();
        applyStimulus();
        R_Addr = {5'd0, 5'd3}; R_En = 2'b01;
        tick();
        applyStimulus();
        checkOutput("sb_clr_busy", 32'(R_Busy[0]), 32'd0);
        checkOutput("sb_clr_data", port(0), 32'h55);
        W_Addr0 = 5'd3; W_Data0 = 32'h66; Write_Reg0 = 1'b1;
        Issue_En = 1'b1; Issue_Addr = 5'd3;
        tick();
        applyStimulus();
        R_Addr = {5'd3, 5'd0}; R_En = 2'b10;
        tick();
        applyStimulus();
        checkOutput("sb_both_busy", 32'(R_Busy[1]), 32'd1);
        checkOutput("sb_both_data", port(1), 32'h66);

        // Same-edge write and read of register 9 with a pending issue.
        W_Addr0 = 5'd9; W_Data0 = 32'h99; Write_Reg0 = 1'b1;
        tick();
        applyStimulus();
        Issue_En = 1'b1; Issue_Addr = 5'd9;
        tick();
        applyStimulus();
        W_Addr0 = 5'd9; W_Data0 = 32'hA5; Write_Reg0 = 1'b1;
        R_Addr = {5'd0, 5'd9}; R_En = 2'b01;
        tick();
        applyStimulus();
`ifdef REGISTER_FILE_MP_BYPASS_EN
        checkOutput("byp_data", port(0), 32'hA5);
        checkOutput("byp_busy", 32'(R_Busy[0]), 32'd0);
`else
        checkOutput("byp_data", port(0), 32'h99);
        checkOutput("byp_busy", 32'(R_Busy[0]), 32'd1);
`endif
        R_Addr = {5'd0, 5'd9}; R_En = 2'b01;
        tick();
        applyStimulus();
        checkOutput("after_byp_data", port(0), 32'hA5);
        checkOutput("after_byp_busy", 32'(R_Busy[0]), 32'd0);

        // Both ports write register 10 while port 1 reads it at the same edge.
        W_Addr0 = 5'd10; W_Data0 = 32'hAAAA; Write_Reg0 = 1'b1;
        W_Addr1 = 5'd10; W_Data1 = 32'hBBBB; Write_Reg1 = 1'b1;
        R_Addr = {5'd10, 5'd0}; R_En = 2'b10;
        tick();
        applyStimulus();
`ifdef REGISTER_FILE_MP_BYPASS_EN
        checkOutput("byp_col_data", port(1), 32'hBBBB);
`else
        checkOutput("byp_col_data", port(1), 32'h0);
`endif

        // Reset overrides a concurrent write, issue and read.
        Reset = 1'b1;
        W_Addr0 = 5'd12; W_Data0 = 32'h1234; Write_Reg0 = 1'b1;
        Issue_En = 1'b1; Issue_Addr = 5'd4;
        R_Addr = {5'd7, 5'd5}; R_En = 2'b11;
        tick();
        applyStimulus();
        checkOutput("rst_valid", 32'(R_Valid), 32'd0);
        checkOutput("rst_data_p0", port(0), 32'd0);
        checkOutput("rst_data_p1", port(1), 32'd0);
        checkOutput("rst_busy", 32'(R_Busy), 32'd0);
        tick();
        checkOutput("rst_drop_valid", 32'(R_Valid), 32'd0);

        // Every register reads zero and not busy after reset.
        for (int a = 0; a < 32; a += 2) begin
            R_Addr = {5'(a + 1), 5'(a)}; R_En = 2'b11;
            tick();
            checkOutput($sformatf("sweep_p0_%0d", a), port(0), 32'd0);
            checkOutput($sformatf("sweep_p1_%0d", a + 1), port(1), 32'd0);
            checkOutput($sformatf("sweep_busy_%0d", a), 32'(R_Busy), 32'd0);
            checkOutput($sformatf("sweep_valid_%0d", a), 32'(R_Valid), 32'd3);
        end
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
